// File: rtl/m_ext_mul_issue.sv
// rtl/m_ext_mul_issue.sv - RV32M multiplier issue/handshake front end; optional result cache under M_ISSUE_REUSE_EN
module m_ext_mul_issue #(
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_funct3_i,
    input  logic [31:0]      req_rs1_i,
    input  logic [31:0]      req_rs2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [31:0]      resp_result_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             resp_err_o,
    output logic             busy_o,
    output logic             mult_en_o,
    output logic [31:0]      op_A_o,
    output logic [31:0]      op_B_o,
    output logic             signed_A_o,
    output logic             signed_B_o,
    output logic             upper_o,
    input  logic [31:0]      mult_result_i,
    input  logic             mult_done_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        accept;
    logic        dec_illegal, dec_sa, dec_sb, dec_up;
    logic        cache_hit;
    logic [31:0] cache_result;
    logic        mult_complete;

    assign req_ready_o   = (state_q == S_IDLE) && !flush_i && !rst_i;
    assign accept        = req_valid_i && req_ready_o;
    assign mult_complete = (state_q == S_BUSY) && mult_done_i && !flush_i;

    always_comb begin
        dec_illegal = 1'b0;
        dec_sa      = 1'b0;
        dec_sb      = 1'b0;
        dec_up      = 1'b0;
        case (req_funct3_i)
            3'b000: dec_up = 1'b0;
            3'b001: begin
                dec_sa = 1'b1;
                dec_sb = 1'b1;
                dec_up = 1'b1;
            end
            3'b010: begin
                dec_sa = 1'b1;
                dec_up = 1'b1;
            end
            3'b011: dec_up = 1'b1;
            default: dec_illegal = 1'b1;
        endcase
    end

`ifdef M_ISSUE_REUSE_EN
    logic        cache_valid_q;
    logic [2:0]  cache_funct3_q, funct3_q;
    logic [31:0] cache_rs1_q, cache_rs2_q, cache_result_q;

    assign cache_hit = cache_valid_q && !dec_illegal && (cache_funct3_q == req_funct3_i)
                    && (cache_rs1_q == req_rs1_i) && (cache_rs2_q == req_rs2_i);
    assign cache_result = cache_result_q;

    // Entry survives flushes; only a completed, non-flushed multiply replaces it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cache_valid_q  <= 1'b0;
            cache_funct3_q <= 3'b000;
            funct3_q       <= 3'b000;
            cache_rs1_q    <= 32'h0;
            cache_rs2_q    <= 32'h0;
            cache_result_q <= 32'h0;
        end else begin
            if (accept) begin
                funct3_q <= req_funct3_i;
            end
            if (mult_complete) begin
                cache_valid_q  <= 1'b1;
                cache_funct3_q <= funct3_q;
                cache_rs1_q    <= op_A_o;
                cache_rs2_q    <= op_B_o;
                cache_result_q <= mult_result_i;
            end
        end
    end
`else
    assign cache_hit    = 1'b0;
    assign cache_result = 32'h0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (dec_illegal || cache_hit) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: state_d = flush_i ? S_DRAIN : S_BUSY;
            S_BUSY: begin
                // A flush landing on the done cycle has nothing left to drain.
                if (flush_i) begin
                    state_d = mult_done_i ? S_IDLE : S_DRAIN;
                end else if (mult_done_i) begin
                    state_d = S_RESP;
                end
            end
            S_DRAIN: begin
                if (mult_done_i) begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                if (flush_i || resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            resp_valid_o  <= 1'b0;
            busy_o        <= 1'b0;
            mult_en_o     <= 1'b0;
            resp_result_o <= 32'h0;
            resp_tag_o    <= '0;
            resp_err_o    <= 1'b0;
            op_A_o        <= 32'h0;
            op_B_o        <= 32'h0;
            signed_A_o    <= 1'b0;
            signed_B_o    <= 1'b0;
            upper_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_o <= (state_d == S_RESP);
            busy_o       <= (state_d != S_IDLE);
            mult_en_o    <= (state_d == S_LAUNCH);
            if (accept) begin
                op_A_o        <= req_rs1_i;
                op_B_o        <= req_rs2_i;
                signed_A_o    <= dec_sa;
                signed_B_o    <= dec_sb;
                upper_o       <= dec_up;
                resp_tag_o    <= req_tag_i;
                resp_err_o    <= dec_illegal;
                resp_result_o <= (cache_hit && !dec_illegal) ? cache_result : 32'h0;
            end
            if (mult_complete) begin
                resp_result_o <= mult_result_i;
            end
        end
    end

endmodule

// File: tb/tb_m_ext_mul_issue.sv
// tb/tb_m_ext_mul_issue.sv - scoreboard bench for m_ext_mul_issue with a 7-cycle multiplier model
module tb_m_ext_mul_issue;
    localparam int TAG_W = 5;
    localparam int N     = 7;
`ifdef M_ISSUE_REUSE_EN
    localparam int HIT_EN  = 0;
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_EN  = 1;
    localparam int HIT_LAT = 9;
`endif

    logic             clk, rst, flush;
    logic             req_valid, req_ready;
    logic [2:0]       req_funct3;
    logic [31:0]      req_rs1, req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid, resp_ready;
    logic [31:0]      resp_result;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err, busy, mult_en;
    logic [31:0]      op_a, op_b;
    logic             signed_a, signed_b, upper;
    logic [31:0]      mult_result;
    logic             mult_done;

    int total = 0;
    int bad   = 0;

    m_ext_mul_issue #(.TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_funct3_i(req_funct3),
        .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_tag_i(req_tag),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_result_o(resp_result),
        .resp_tag_o(resp_tag), .resp_err_o(resp_err), .busy_o(busy), .mult_en_o(mult_en),
        .op_A_o(op_a), .op_B_o(op_b), .signed_A_o(signed_a), .signed_B_o(signed_b),
        .upper_o(upper), .mult_result_i(mult_result), .mult_done_i(mult_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: done for one cycle N cycles after the mult_en cycle
    logic [63:0] prod_q;
    logic        up_q;
    logic [3:0]  cnt_q;

    function automatic logic [63:0] mulx(input logic [31:0] a, input logic [31:0] b,
                                         input logic sa, input logic sb);
        logic signed [63:0] ea, eb;
        ea = sa ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'h0, b};
        return 64'(ea * eb);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 4'd0;
            prod_q <= 64'h0;
            up_q   <= 1'b0;
        end else if (mult_en) begin
            cnt_q  <= 4'(N);
            prod_q <= mulx(op_a, op_b, signed_a, signed_b);
            up_q   <= upper;
        end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end
    assign mult_done   = (cnt_q == 4'd1);
    assign mult_result = up_q ? prod_q[63:32] : prod_q[31:0];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    typedef struct packed {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;
    exp_t expq[$];

    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (expq.size() == 0) begin
                fail_now("unexpected_resp");
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("resp_result", 64'(resp_result), 64'(e.res));
                chk("resp_tag", 64'(resp_tag), 64'(e.tag));
                chk("resp_err", 64'(resp_err), 64'(e.err));
            end
        end
    end

    // Called just after a posedge; returns just after the handshake edge when resp_ready=1.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tg, input logic [31:0] er, input logic ee,
                         input int exp_en_k, input int exp_resp_k,
                         input logic xsa, input logic xsb, input logic xup);
        int k, en_k, en_cnt;
        logic sa, sb, up;
        sa = 1'b0; sb = 1'b0; up = 1'b0;
        req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_tag = tg;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!req_ready && k < 100);
        if (!req_ready) fail_now("accept_timeout");
        @(posedge clk);
        #1 req_valid = 1'b0;
        expq.push_back('{res: er, tag: tg, err: ee});
        k = 0; en_k = 0; en_cnt = 0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (mult_en) begin
                en_cnt++;
                if (en_k == 0) begin
                    en_k = k; sa = signed_a; sb = signed_b; up = upper;
                end
            end
            if (resp_valid) break;
        end
        chk("resp_latency", 64'(k), 64'(exp_resp_k));
        chk("mult_en_cycle", 64'(en_k), 64'(exp_en_k));
        chk("mult_en_pulses", 64'(en_cnt), (exp_en_k != 0) ? 64'd1 : 64'd0);
        if (exp_en_k != 0) begin
            chk("signed_a", 64'(sa), 64'(xsa));
            chk("signed_b", 64'(sb), 64'(xsb));
            chk("upper", 64'(up), 64'(xup));
        end
        if (resp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        fail_now("global_timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int k;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_funct3 = 3'b000;
        req_rs1 = 32'h0; req_rs2 = 32'h0; req_tag = '0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_outputs", {61'(resp_result) ^ 61'(op_a) ^ 61'(op_b), resp_valid, busy, mult_en}, 64'd0);
        chk("rst_misc", 64'({resp_tag, resp_err, signed_a, signed_b, upper}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // MULHU max x max
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, 1'b0, 1, 9, 1'b0, 1'b0, 1'b1);
        // same operands, four ops
        issue(3'b000, 32'hFFFFFFFF, 32'h2, 5'd1, 32'hFFFFFFFE, 1'b0, 1, 9, 1'b0, 1'b0, 1'b0);
        issue(3'b001, 32'hFFFFFFFF, 32'h2, 5'd2, 32'hFFFFFFFF, 1'b0, 1, 9, 1'b1, 1'b1, 1'b1);
        issue(3'b010, 32'hFFFFFFFF, 32'h2, 5'd4, 32'hFFFFFFFF, 1'b0, 1, 9, 1'b1, 1'b0, 1'b1);
        issue(3'b011, 32'hFFFFFFFF, 32'h2, 5'd6, 32'h00000001, 1'b0, 1, 9, 1'b0, 1'b0, 1'b1);
        // illegal funct3
        issue(3'b100, 32'h5, 32'h6, 5'd7, 32'h0, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0);

        // response backpressure: ready low for 5 cycles of RESP
        resp_ready = 1'b0;
        issue(3'b000, 32'd3, 32'd7, 5'd9, 32'd21, 1'b0, 1, 9, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_result", 64'(resp_result), 64'd21);
            chk("hold_tag", 64'(resp_tag), 64'd9);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            chk("hold_busy", 64'(busy), 64'd1);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_hs_busy", 64'(busy), 64'd0);
        chk("idle_after_hs_valid", 64'(resp_valid), 64'd0);

        // flush in BUSY at cycle 4
        @(posedge clk);
        #1 req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'd3; req_rs2 = 32'd5; req_tag = 5'd4;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!req_ready && k < 100);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        for (int c = 5; c <= 8; c++) begin
            @(negedge clk);
            chk("drain_busy", 64'(busy), 64'd1);
            chk("drain_no_resp", 64'(resp_valid), 64'd0);
        end
        @(negedge clk);
        chk("post_drain_busy", 64'(busy), 64'd0);
        chk("post_drain_ready", 64'(req_ready), 64'd1);
        // flush in IDLE blocks acceptance
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        // the flushed MUL 3x5 must not have been cached
        issue(3'b000, 32'd3, 32'd5, 5'd5, 32'd15, 1'b0, 1, 9, 1'b0, 1'b0, 1'b0);

        // repeated MULH(-1, 2)
        issue(3'b001, 32'hFFFFFFFF, 32'h2, 5'd10, 32'hFFFFFFFF, 1'b0, 1, 9, 1'b1, 1'b1, 1'b1);
        issue(3'b001, 32'hFFFFFFFF, 32'h2, 5'd11, 32'hFFFFFFFF, 1'b0, HIT_EN, HIT_LAT, 1'b1, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/m_ext_mul_issue.md
# m_ext_mul_issue

Issue/handshake front end for the RV32M multiplier. It sits directly upstream of the multiplier top and accepts decoded MUL/MULH/MULHSU/MULHU requests from the core over a valid/ready channel. It maps each funct3 to the multiplier's signedness and upper-half controls, then launches the multiplier and holds its operands stable until done. The 32-bit result is returned on a valid/ready response channel with tag, error flag and flush support.

## Interface
- TAG_W, 5, width of request/response tag (destination register id)
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  abort in-flight request; drop pending response
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_funct3_i  in  3  RV32M funct3
- req_rs1_i  in  32  operand A
- req_rs2_i  in  32  operand B
- req_tag_i  in  TAG_W  request tag
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed when valid&ready
- resp_result_o  out  32  result
- resp_tag_o  out  TAG_W  echoed tag
- resp_err_o  out  1  illegal funct3
- busy_o  out  1  state != IDLE
- mult_en_o  out  1  multiplier start, to mult_en_i
- op_A_o, op_B_o  out  32  to multiplier op_A_i/op_B_i
- signed_A_o, signed_B_o, upper_o  out  1  to multiplier controls
- mult_result_i  in  32  from multiplier result_o
- mult_done_i  in  1  from multiplier done_o

## Operation
- States: IDLE, LAUNCH, BUSY, DRAIN, RESP.
- Decode, registered at accept. 000 MUL: sA=0 sB=0 up=0. 001 MULH: 1,1,1. 010 MULHSU: 1,0,1. 011 MULHU: 0,0,1. 1xx: illegal.
- IDLE: req_ready_o = !flush_i. On accept, capture rs1, rs2, decode and tag.
  - Legal: go to LAUNCH.
  - Illegal: go to RESP with err=1, result=0, no mult_en_o.
- LAUNCH: mult_en_o=1 for exactly one cycle, then BUSY.
- BUSY: wait for the first cycle with mult_done_i=1. Capture mult_result_i, then RESP.
- RESP: resp_valid_o=1 with result/tag/err held stable until resp_ready_i. Then IDLE. No new request is accepted in RESP.
- op_A_o, op_B_o, signed_*_o and upper_o are registered. They change only on accept and stay stable from LAUNCH through the done cycle.
- flush_i handling:
  - In LAUNCH or BUSY: go to DRAIN. Wait for mult_done_i, discard the result, then IDLE.
  - In RESP: drop the response, go to IDLE.
  - In IDLE: blocks acceptance.
  - In DRAIN: no effect.
- mult_done_i outside BUSY/DRAIN is ignored.
- Reset mid-operation: next state IDLE, no drain. The multiplier shares rst_i.
- Reset values: every output 0, except busy_o=0 and req_ready_o=0 while rst_i=1. req_ready_o=1 from the first cycle after reset deasserts.

## Timing
- Accept at cycle 0; mult_en_o at cycle 1.
- With multiplier done N cycles after mult_en: capture at 1+N, resp_valid_o at 2+N. Current multiplier: N=7, response at cycle 9.
- Illegal request: resp_valid_o at cycle 1.
- Throughput: one request per N+3 cycles when resp_ready_i=1. The next request is accepted the cycle after response handshake.
- Outputs are registered except req_ready_o (state & !flush_i).

## Configuration
- M_ISSUE_REUSE_EN defined: single-entry result cache holding {valid, funct3, rs1, rs2, result}.
  - Written on every non-flushed multiplier completion; cleared only by reset.
  - A legal accepted request matching the entry goes IDLE→RESP directly: resp_valid_o at cycle 1, cached result, no mult_en_o.
- M_ISSUE_REUSE_EN undefined: no cache; every legal request launches the multiplier.

## Test plan
- MULHU 0xFFFFFFFF×0xFFFFFFFF, tag 3, N=7:
  - mult_en_o pulse at cycle 1 with signed 0/0, upper 1.
  - resp at cycle 9: result 0xFFFFFFFE, tag 3, err 0.
- Same operands (0xFFFFFFFF, 2) under four ops:
  - MUL → 0xFFFFFFFE
  - MULH → 0xFFFFFFFF
  - MULHSU → 0xFFFFFFFF
  - MULHU → 0x00000001
  - Check controls per decode table.
- funct3=100: resp at cycle 1, err=1, result 0, mult_en_o never asserts.
- resp_ready_i low 5 cycles in RESP:
  - resp fields stable, req_ready_o=0, busy_o=1.
  - Handshake on cycle 6, IDLE next.
- flush_i in BUSY at cycle 4:
  - no response, busy_o=1 until done at cycle 8, IDLE at 9.
  - Following MUL 3×5 returns 15.
- Repeat identical MULH (−1, 2) twice:
  - With M_ISSUE_REUSE_EN: second resp at cycle 1, no mult_en_o.
  - Without: second resp at cycle 9.
